// File: rtl/mem_pkg.sv
// Shared encodings for the memory arbiter: FSM states and grant sources.
package mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_IFETCH = 3'd1,
      ST_DREAD  = 3'd2,
      ST_DWRITE = 3'd3,
      ST_DMA    = 3'd4
   } mem_state_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_CORE = 2'd1,
      SRC_DMA  = 2'd2
   } grant_src_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant select: core write > read > fetch, core vs DMA alternates.
module arb_pick
   import mem_pkg::*;
(
   input  logic       write,
   input  logic       read,
   input  logic       fetch,
   input  logic       dma,
   input  logic       last_dma,
   output grant_src_t src,
   output mem_state_t pick
);

   logic core;
   assign core = write | read | fetch;

   always_comb begin
      src  = SRC_NONE;
      pick = ST_IDLE;
      // DMA yields to the core only when it also won the previous grant.
      if (dma && (!core || !last_dma)) begin
         src  = SRC_DMA;
         pick = ST_DMA;
      end else if (core) begin
         src = SRC_CORE;
         if (write)     pick = ST_DWRITE;
         else if (read) pick = ST_DREAD;
         else           pick = ST_IFETCH;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter between core fetch/load/store and a DMA master.
// Handshake: m_req and all m_* payload are registered at grant and held until a
// one-cycle m_ack; the matching done pulse and read data appear in that cycle.
module mem_arb
   import mem_pkg::*;
#(
   parameter int RV = 32,
   parameter int VA = RV
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ifetch,
   input  logic [VA-1:1]         pc,
   input  logic [VA-1:RV/16]     addr,
   input  logic [1:0]            rstrobe,
   input  logic [RV/8-1:0]       wmask,
   input  logic [RV-1:0]         wdata,
   input  logic                  io_access,
   output logic                  idone,
   output logic                  rdone,
   output logic                  wdone,
   output logic [RV-1:0]         rdata,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [VA-1:RV/16]     dma_addr,
   input  logic [RV-1:0]         dma_wdata,
   input  logic [RV/8-1:0]       dma_wmask,
   output logic                  dma_done,
   output logic [RV-1:0]         dma_rdata,
   output logic                  m_req,
   output logic                  m_we,
   output logic                  m_io,
   output logic [VA-1:RV/16]     m_addr,
   output logic [RV-1:0]         m_wdata,
   output logic [RV/8-1:0]       m_wmask,
   output logic [1:0]            m_rstrobe,
   input  logic                  m_ack,
   input  logic [RV-1:0]         m_rdata,
   output mem_state_t            dbg_state
);

   localparam int AW  = VA - RV/16;
   localparam int LSB = RV/16;

   mem_state_t state, state_next, pick;
   grant_src_t src;
   logic       last_dma;
   logic       grant;
   logic       ack_ok;
   logic [AW-1:0] fetch_addr;

   // pc is a halfword address; drop the extra low bit(s) to get a word address.
   assign fetch_addr = AW'({pc, 1'b0} >> LSB);

   arb_pick u_pick (
      .write    (|wmask),
      .read     (|rstrobe),
      .fetch    (ifetch),
      .dma      (dma_req),
      .last_dma (last_dma),
      .src      (src),
      .pick     (pick)
   );

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      if (state == ST_IDLE) begin
         grant      = (src != SRC_NONE);
         state_next = pick;
      end else if (m_ack) begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_dma  <= 1'b0;
         m_req     <= 1'b0;
         m_we      <= 1'b0;
         m_io      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         m_wmask   <= '0;
         m_rstrobe <= 2'b00;
      end else if (grant) begin
         m_req    <= 1'b1;
         last_dma <= (src == SRC_DMA);
         unique case (pick)
            ST_IFETCH: begin
               m_addr <= fetch_addr; m_we <= 1'b0; m_io <= 1'b0;
               m_wmask <= '0; m_wdata <= '0; m_rstrobe <= 2'b11;
            end
            ST_DREAD: begin
               m_addr <= addr; m_we <= 1'b0; m_io <= io_access;
               m_wmask <= '0; m_wdata <= '0; m_rstrobe <= rstrobe;
            end
            ST_DWRITE: begin
               m_addr <= addr; m_we <= 1'b1; m_io <= io_access;
               m_wmask <= wmask; m_wdata <= wdata; m_rstrobe <= 2'b00;
            end
            default: begin
               m_addr <= dma_addr; m_we <= dma_we; m_io <= 1'b0;
               m_wmask <= dma_we ? dma_wmask : '0;
               m_wdata <= dma_wdata;
               m_rstrobe <= dma_we ? 2'b00 : 2'b11;
            end
         endcase
      end else if (state != ST_IDLE && m_ack) begin
         m_req <= 1'b0;
      end
   end

   // A reset in the ack cycle abandons the transaction, so suppress done then.
   assign ack_ok    = m_ack && !reset;
   assign idone     = ack_ok && (state == ST_IFETCH);
   assign rdone     = ack_ok && (state == ST_DREAD);
   assign wdone     = ack_ok && (state == ST_DWRITE);
   assign dma_done  = ack_ok && (state == ST_DMA);
   assign rdata     = m_rdata;
   assign dma_rdata = m_rdata;
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: fetch, priority order, DMA fairness, reset abort,
// spurious ack and DMA write, all with hand-computed expectations.
module tb_mem_arb;
   import mem_pkg::*;

   localparam int RV = 32;
   localparam int VA = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              ifetch;
   logic [VA-1:1]     pc;
   logic [VA-1:2]     addr;
   logic [1:0]        rstrobe;
   logic [3:0]        wmask;
   logic [RV-1:0]     wdata;
   logic              io_access;
   logic              idone, rdone, wdone;
   logic [RV-1:0]     rdata;
   logic              dma_req, dma_we;
   logic [VA-1:2]     dma_addr;
   logic [RV-1:0]     dma_wdata;
   logic [3:0]        dma_wmask;
   logic              dma_done;
   logic [RV-1:0]     dma_rdata;
   logic              m_req, m_we, m_io;
   logic [VA-1:2]     m_addr;
   logic [RV-1:0]     m_wdata;
   logic [3:0]        m_wmask;
   logic [1:0]        m_rstrobe;
   logic              m_ack;
   logic [RV-1:0]     m_rdata;
   mem_state_t        dbg_state;

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q[$];

   mem_arb #(.RV(RV), .VA(VA)) dut (
      .clk(clk), .reset(reset), .ifetch(ifetch), .pc(pc), .addr(addr),
      .rstrobe(rstrobe), .wmask(wmask), .wdata(wdata), .io_access(io_access),
      .idone(idone), .rdone(rdone), .wdone(wdone), .rdata(rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_wmask(dma_wmask), .dma_done(dma_done),
      .dma_rdata(dma_rdata), .m_req(m_req), .m_we(m_we), .m_io(m_io),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
      .m_rstrobe(m_rstrobe), .m_ack(m_ack), .m_rdata(m_rdata),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dones(input string tag, input logic [3:0] exp);
      chk(tag, {60'd0, idone, rdone, wdone, dma_done}, {60'd0, exp});
   endtask

   // Called at a negedge in a busy state: ack now, check pulse, then check IDLE.
   task automatic serve(input mem_state_t exp_st, input logic [RV-1:0] rd);
      logic [3:0] exp_done;
      chk("busy_state", dbg_state, exp_st);
      chk("busy_m_req", m_req, 1'b1);
      exp_done = {exp_st == ST_IFETCH, exp_st == ST_DREAD,
                  exp_st == ST_DWRITE, exp_st == ST_DMA};
      m_ack = 1'b1; m_rdata = rd;
      #1;
      chk_dones("ack_dones", exp_done);
      if (exp_st == ST_DMA) chk("dma_rdata", dma_rdata, rd);
      else                  chk("rdata", rdata, rd);
      @(negedge clk);
      m_ack = 1'b0;
      #1;
      chk_dones("post_ack_dones", 4'b0000);
      chk("post_ack_state", dbg_state, ST_IDLE);
      chk("post_ack_m_req", m_req, 1'b0);
   endtask

   initial begin
      reset = 1'b1; ifetch = 0; pc = '0; addr = '0; rstrobe = 0; wmask = 0;
      wdata = '0; io_access = 0; dma_req = 0; dma_we = 0; dma_addr = '0;
      dma_wdata = '0; dma_wmask = 0; m_ack = 0; m_rdata = '0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_state", dbg_state, ST_IDLE);
      chk("rst_m_req", m_req, 1'b0);
      chk("rst_m_we", m_we, 1'b0);
      chk("rst_m_addr", m_addr, 30'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_m_wmask", m_wmask, 4'd0);
      chk("rst_m_rstrobe", m_rstrobe, 2'd0);
      chk("rst_m_io", m_io, 1'b0);
      chk_dones("rst_dones", 4'b0000);

      // DMA and fetch held together: DMA first after reset, then alternate
      reset = 1'b0; dma_req = 1; dma_we = 0; dma_addr = 30'h10; ifetch = 1; pc = 31'h8;
      exp_q.push_back(ST_DMA); exp_q.push_back(ST_IFETCH);
      exp_q.push_back(ST_DMA); exp_q.push_back(ST_IFETCH);
      while (exp_q.size() > 0) begin
         logic [2:0] e;
         e = exp_q.pop_front();
         @(negedge clk);
         if (e == ST_DMA) begin
            chk("alt_dma_addr", m_addr, 30'h10);
            chk("alt_dma_rstrobe", m_rstrobe, 2'b11);
         end else begin
            chk("alt_fetch_addr", m_addr, 30'h4);
         end
         serve(mem_state_t'(e), 32'h100 + RV'(e));
      end
      dma_req = 0; ifetch = 0;
      @(negedge clk);
      chk("alt_end_state", dbg_state, ST_IDLE);

      // fetch pc=0x40 with ack three cycles after m_req
      ifetch = 1; pc = 31'h40;
      @(negedge clk);
      chk("fetch_m_addr", m_addr, 30'h20);
      chk("fetch_m_rstrobe", m_rstrobe, 2'b11);
      chk("fetch_m_we", m_we, 1'b0);
      chk("fetch_m_io", m_io, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk_dones("fetch_wait_dones", 4'b0000);
         chk("fetch_wait_m_req", m_req, 1'b1);
      end
      serve(ST_IFETCH, 32'h12345678);
      ifetch = 0;
      @(negedge clk);
      chk("fetch_idle_m_req", m_req, 1'b0);

      // write > read > fetch, one IDLE between each
      wmask = 4'b0100; wdata = 32'hDEADBEEF; rstrobe = 2'b01; ifetch = 1;
      addr = 30'h11; io_access = 1; pc = 31'h10;
      @(negedge clk);
      chk("wr_m_we", m_we, 1'b1);
      chk("wr_m_wmask", m_wmask, 4'b0100);
      chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
      chk("wr_m_rstrobe", m_rstrobe, 2'b00);
      chk("wr_m_io", m_io, 1'b1);
      chk("wr_m_addr", m_addr, 30'h11);
      serve(ST_DWRITE, 32'h0);
      wmask = 0;
      @(negedge clk);
      chk("rd_m_we", m_we, 1'b0);
      chk("rd_m_rstrobe", m_rstrobe, 2'b01);
      serve(ST_DREAD, 32'hCAFEF00D);
      rstrobe = 0;
      @(negedge clk);
      chk("if_m_addr", m_addr, 30'h8);
      chk("if_m_io", m_io, 1'b0);
      serve(ST_IFETCH, 32'h55AA55AA);
      ifetch = 0; io_access = 0;
      @(negedge clk);
      chk("prio_end_state", dbg_state, ST_IDLE);

      // reset during DREAD before ack
      rstrobe = 2'b11; addr = 30'h5;
      @(negedge clk);
      chk("rr_state", dbg_state, ST_DREAD);
      @(negedge clk);
      reset = 1; rstrobe = 0;
      #1;
      chk_dones("rr_reset_dones", 4'b0000);
      @(negedge clk);
      reset = 0;
      chk("rr_m_req", m_req, 1'b0);
      chk("rr_state_idle", dbg_state, ST_IDLE);
      chk_dones("rr_after_dones", 4'b0000);

      // spurious ack in IDLE
      @(negedge clk);
      m_ack = 1; m_rdata = 32'hFFFFFFFF;
      #1;
      chk_dones("spur_dones", 4'b0000);
      @(negedge clk);
      m_ack = 0;
      chk("spur_state", dbg_state, ST_IDLE);
      chk("spur_m_req", m_req, 1'b0);
      chk("spur_m_addr", m_addr, 30'd0);

      // DMA write, payload held while dma inputs change
      dma_req = 1; dma_we = 1; dma_wmask = 4'b1111; dma_wdata = 32'hA5A5A5A5;
      dma_addr = 30'h3C;
      @(negedge clk);
      dma_wdata = 32'h0; dma_addr = 30'h0;
      chk("dw_m_we", m_we, 1'b1);
      chk("dw_m_wdata", m_wdata, 32'hA5A5A5A5);
      chk("dw_m_rstrobe", m_rstrobe, 2'b00);
      chk("dw_m_wmask", m_wmask, 4'b1111);
      chk("dw_m_addr", m_addr, 30'h3C);
      @(negedge clk);
      chk("dw_hold_wdata", m_wdata, 32'hA5A5A5A5);
      chk("dw_hold_addr", m_addr, 30'h3C);
      serve(ST_DMA, 32'h0);
      dma_req = 0;
      @(negedge clk);
      chk("dw_end_state", dbg_state, ST_IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameters: RV, default 32, data width (16 or 32); VA, default RV, virtual address width.
REQ-002 SHALL have ports, clock and reset first: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have core-side ports: ifetch  in  1  instruction fetch request; pc  in  VA-1  fetch halfword address [VA-1:1]; addr  in  VA-RV/16  data address [VA-1:RV/16]; rstrobe  in  2  data read request/byte strobes; wmask  in  RV/8  data write request/byte enables; wdata  in  RV  write data; io_access  in  1  IO-space qualifier.
REQ-004 SHALL have core-side outputs: idone  out  1  fetch complete pulse; rdone  out  1  read complete pulse; wdone  out  1  write complete pulse; rdata  out  RV  read/fetch data.
REQ-005 SHALL have DMA ports: dma_req  in  1; dma_we  in  1; dma_addr  in  VA-RV/16; dma_wdata  in  RV; dma_wmask  in  RV/8; dma_done  out  1  completion pulse; dma_rdata  out  RV.
REQ-006 SHALL have memory ports: m_req  out  1; m_we  out  1; m_io  out  1; m_addr  out  VA-RV/16; m_wdata  out  RV; m_wmask  out  RV/8; m_rstrobe  out  2; m_ack  in  1  one-cycle completion; m_rdata  in  RV  valid when m_ack.

Function
REQ-007 SHALL be a FSM with states IDLE, IFETCH, DREAD, DWRITE, DMA.
REQ-008 SHALL in IDLE sample requests: write = |wmask, read = |rstrobe, fetch = ifetch, dma = dma_req.
REQ-009 SHALL order core requests write > read > fetch.
REQ-010 SHALL arbitrate core vs DMA by alternation: 1-bit last_dma flag; when both request, DMA wins iff last_dma==0; lone requester always wins.
REQ-011 SHALL register all m_* outputs at the grant edge and hold them stable until m_ack.
REQ-012 SHALL drive for IFETCH: m_addr = pc[VA-1:RV/16], m_we=0, m_rstrobe=2'b11, m_io=0.
REQ-013 SHALL drive for DREAD/DWRITE: m_addr=addr, m_io=io_access, m_rstrobe=rstrobe (read) or 0 (write), m_wmask/m_wdata from core (write).
REQ-014 SHALL drive for DMA: m_addr=dma_addr, m_we=dma_we, m_wmask=dma_we?dma_wmask:0, m_rstrobe=dma_we?0:2'b11, m_io=0.
REQ-015 SHALL, on m_ack, drop m_req on the next edge, return to IDLE, and assert the matching done pulse combinationally in the m_ack cycle; rdata/dma_rdata = m_rdata in that cycle.
REQ-016 SHALL force one IDLE cycle between transactions, so a requester deasserting the cycle after its done pulse is never re-issued.
REQ-017 SHALL have a minimum latency of request-in-IDLE cycle N -> m_req cycle N+1 -> done at the m_ack cycle (≥ N+1).
REQ-018 SHALL ignore m_ack in IDLE; no done pulse, no state change.
REQ-019 SHALL ignore request changes during an active transaction; the latched request completes.
REQ-020 SHALL set last_dma=1 on DMA grant and last_dma=0 on core grant.

Reset
REQ-021 SHALL on reset: state=IDLE, last_dma=0, m_req=0, m_we=0, m_wmask=0, m_rstrobe=0, m_io=0, m_addr=0, m_wdata=0; idone=rdone=wdone=dma_done=0.
REQ-022 SHALL abandon an in-flight transaction on reset mid-operation; no done pulse; m_req=0 from the next cycle.

Structure
REQ-023 SHALL define state encodings (IDLE..DMA) and grant-source constants in shared package mem_pkg.
REQ-024 SHALL be a single module; an optional sub-module arb_pick (combinational priority/fairness select) is permitted.

Verification
REQ-025 SHALL verify: ifetch=1, pc=0x40 (RV=32), m_ack 3 cycles after m_req, m_rdata=0x12345678 -> m_addr=0x20, idone one cycle with rdata=0x12345678, m_req low next cycle.
REQ-026 SHALL verify: wmask=4'b0100, rstrobe!=0 and ifetch together -> DWRITE first, then DREAD, then IFETCH, each separated by one IDLE cycle.
REQ-027 SHALL verify: dma_req and ifetch held continuously -> grants alternate DMA, core, DMA, core; first grant DMA after reset.
REQ-028 SHALL verify: reset asserted during DREAD before m_ack -> no rdone, m_req=0 next cycle, state IDLE.
REQ-029 SHALL verify: spurious m_ack in IDLE -> no done pulses, outputs unchanged.
REQ-030 SHALL verify: DMA write dma_we=1, dma_wmask=4'b1111, dma_wdata=0xA5A5A5A5 -> m_we=1, m_wdata=0xA5A5A5A5, m_rstrobe=0, dma_done at m_ack.
